// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - pause codes, scoreboard entry type and match helper
package hazard_unit_pkg;

  localparam int HAZARD_DEPTH_DEFAULT = 3;

  localparam logic [1:0] PAUSE_NO   = 2'b00;
  localparam logic [1:0] PAUSE_RS   = 2'b01;
  localparam logic [1:0] PAUSE_RT   = 2'b10;
  localparam logic [1:0] PAUSE_BOTH = 2'b11;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
  } sb_entry_t;

  function automatic logic src_hit(input sb_entry_t e, input logic [4:0] src);
    return e.v && (e.dst == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination shift register with rs/rt match ports
module hazard_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH = HAZARD_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  sb_entry_t  new_entry,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       rs_match,
  output logic       rt_match
);

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];

  // Entry 0 is EX; the WB entry still blocks because the register file writes at the end of WB.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) sb_d[i] = sb_q[i];
    if (shift_en) begin
      sb_d[0] = new_entry;
      for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
    end
  end

  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (src_hit(sb_q[i], rs)) rs_match = 1'b1;
      if (src_hit(sb_q[i], rt)) rt_match = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - issue-side RAW hazard detector, stall generation and stall statistics
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int HAZARD_DEPTH = HAZARD_DEPTH_DEFAULT,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_reg,
  input  logic             hold,
  input  logic             pause_out,
  output logic [1:0]       pause_in,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  localparam int                RUN_W     = $clog2(HAZARD_DEPTH + 2);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(HAZARD_DEPTH);

  logic       stall;
  logic       rs_match, rt_match;
  sb_entry_t  new_entry;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             stall_err_q, stall_err_d;

  // rst_n gating drops the stall outputs in the same cycle the scoreboard is flushed.
  assign stall = pause_out & ~hold & rst_n;

  assign new_entry.v   = id_valid & ~pause_out & id_wr_en & (id_wr_reg != 5'd0);
  assign new_entry.dst = id_wr_reg;

  hazard_scoreboard #(.DEPTH(HAZARD_DEPTH)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (~hold),
    .new_entry (new_entry),
    .rs        (id_rs),
    .rt        (id_rt),
    .rs_match  (rs_match),
    .rt_match  (rt_match)
  );

  // RS wins; shifts carry rs=0 so their rt dependency is still reported.
  always_comb begin
    pause_in = PAUSE_NO;
    if (id_valid && (id_rs != 5'd0) && rs_match)      pause_in = PAUSE_RS;
    else if (id_valid && (id_rt != 5'd0) && rt_match) pause_in = PAUSE_RT;
  end

  assign pc_stall     = stall;
  assign if_id_stall  = stall;
  assign id_ex_bubble = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_d       = run_q;
    stall_err_d = stall_err_q;
    if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (run_q == RUN_LIMIT) stall_err_d = 1'b1;
      else                    run_d       = run_q + RUN_W'(1);
    end else if (!hold) begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      run_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        id_wr_en;
  logic        hold;
  logic        pause_out;
  logic [1:0]  pause_in;
  logic        pc_stall, if_id_stall, id_ex_bubble;
  logic [31:0] stall_cnt;
  logic        stall_err;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit #(.HAZARD_DEPTH(3), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_wr_en     (id_wr_en),
    .id_wr_reg    (id_wr_reg),
    .hold         (hold),
    .pause_out    (pause_out),
    .pause_in     (pause_in),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_bubble (id_ex_bubble),
    .stall_cnt    (stall_cnt),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    id_valid  = 1'b0;
    pause_out = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bench acts as the decoder: pause_out follows pause_in; instruction issues after n_stall stalls.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic we,
                       input logic [4:0] wr, input int n_stall, input logic [1:0] code,
                       input string tag);
    id_valid  = 1'b1;
    id_rs     = rs;
    id_rt     = rt;
    id_wr_en  = we;
    id_wr_reg = wr;
    for (int k = 0; k <= n_stall; k++) begin
      #1;
      pause_out = (pause_in != PAUSE_NO);
      #1;
      if (k < n_stall) begin
        check({tag, "_code"}, 64'(pause_in), 64'(code));
        check({tag, "_bubble"}, 64'(id_ex_bubble), 64'd1);
      end else begin
        check({tag, "_issue"}, 64'(pause_in), 64'(PAUSE_NO));
      end
      @(posedge clk);
      #1;
    end
    pause_out = 1'b0;
    id_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_wr_en = 1'b0; id_wr_reg = '0; hold = 1'b0; pause_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_pause_in", 64'(pause_in), 64'(PAUSE_NO));
    check("rst_pc_stall", 64'(pc_stall), 64'd0);
    check("rst_bubble",   64'(id_ex_bubble), 64'd0);
    check("rst_cnt",      64'(stall_cnt), 64'd0);
    check("rst_err",      64'(stall_err), 64'd0);
    idle(1);

    // add $1,$2,$3 ; add $4,$1,$5
    issue(5'd2, 5'd3, 1'b1, 5'd1, 0, PAUSE_NO, "d1_prod");
    issue(5'd1, 5'd5, 1'b1, 5'd4, 3, PAUSE_RS, "d1_cons");
    check("d1_cnt", 64'(stall_cnt), 64'd3);
    idle(4);

    // ori $7,$0,5 ; add $10,$11,$12 ; sll $8,$7,2
    issue(5'd0,  5'd7,  1'b1, 5'd7,  0, PAUSE_NO, "d2_prod");
    issue(5'd11, 5'd12, 1'b1, 5'd10, 0, PAUSE_NO, "d2_ind");
    issue(5'd0,  5'd7,  1'b1, 5'd8,  2, PAUSE_RT, "d2_sll");
    check("d2_cnt", 64'(stall_cnt), 64'd5);
    idle(4);

    // addi $0,$0,1 ; add $9,$0,$0 ; sw $3,0($1) ; lw $4,0($3)
    issue(5'd0, 5'd0, 1'b1, 5'd0, 0, PAUSE_NO, "z_addi");
    issue(5'd0, 5'd0, 1'b1, 5'd9, 0, PAUSE_NO, "z_add");
    issue(5'd1, 5'd3, 1'b0, 5'd3, 0, PAUSE_NO, "z_sw");
    issue(5'd3, 5'd4, 1'b1, 5'd4, 0, PAUSE_NO, "z_lw");
    check("z_cnt", 64'(stall_cnt), 64'd5);
    idle(4);

    // distance 3 -> one stall, distance 4 -> none
    issue(5'd2,  5'd3,  1'b1, 5'd5,  0, PAUSE_NO, "d3_prod");
    issue(5'd11, 5'd12, 1'b1, 5'd10, 0, PAUSE_NO, "d3_ind0");
    issue(5'd11, 5'd12, 1'b1, 5'd14, 0, PAUSE_NO, "d3_ind1");
    issue(5'd5,  5'd0,  1'b1, 5'd15, 1, PAUSE_RS, "d3_cons");
    idle(4);
    issue(5'd2,  5'd3,  1'b1, 5'd6,  0, PAUSE_NO, "d4_prod");
    issue(5'd11, 5'd12, 1'b1, 5'd10, 0, PAUSE_NO, "d4_ind0");
    issue(5'd11, 5'd12, 1'b1, 5'd14, 0, PAUSE_NO, "d4_ind1");
    issue(5'd11, 5'd12, 1'b1, 5'd16, 0, PAUSE_NO, "d4_ind2");
    issue(5'd6,  5'd0,  1'b1, 5'd17, 0, PAUSE_NO, "d4_cons");
    check("d34_cnt", 64'(stall_cnt), 64'd6);
    idle(4);

    // dependent pair with a 5-cycle hold inside the stall window
    issue(5'd2, 5'd3, 1'b1, 5'd1, 0, PAUSE_NO, "h_prod");
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_wr_en = 1'b1; id_wr_reg = 5'd4;
    #1 pause_out = (pause_in != PAUSE_NO);
    #1 check("h_first_code", 64'(pause_in), 64'(PAUSE_RS));
    @(posedge clk); #1;
    check("h_cnt_first", 64'(stall_cnt), 64'd7);
    hold = 1'b1;
    pause_out = 1'b1;
    repeat (5) begin
      #1;
      check("h_code_frozen", 64'(pause_in), 64'(PAUSE_RS));
      check("h_pc_stall",    64'(pc_stall), 64'd0);
      @(posedge clk); #1;
    end
    check("h_cnt_frozen", 64'(stall_cnt), 64'd7);
    hold = 1'b0;
    issue(5'd1, 5'd5, 1'b1, 5'd4, 2, PAUSE_RS, "h_rest");
    check("h_cnt_total", 64'(stall_cnt), 64'd9);
    check("h_err",       64'(stall_err), 64'd0);
    idle(4);

    // forced pause_out for 4 consecutive cycles
    id_valid = 1'b0;
    pause_out = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("run3_err", 64'(stall_err), 64'd0);
    check("run3_cnt", 64'(stall_cnt), 64'd12);
    @(posedge clk); #1;
    check("run4_err", 64'(stall_err), 64'd1);
    check("run4_cnt", 64'(stall_cnt), 64'd13);
    idle(2);
    check("err_sticky", 64'(stall_err), 64'd1);

    // reset asserted mid-stall
    issue(5'd2, 5'd3, 1'b1, 5'd1, 0, PAUSE_NO, "r_prod");
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_wr_en = 1'b1; id_wr_reg = 5'd4;
    #1 pause_out = (pause_in != PAUSE_NO);
    #1 check("r_stall_before", 64'(pc_stall), 64'd1);
    @(posedge clk); #1;
    check("r_cnt_before", 64'(stall_cnt), 64'd14);
    #1 rst_n = 1'b0;
    #1;
    check("r_pause_in", 64'(pause_in), 64'(PAUSE_NO));
    check("r_pc_stall", 64'(pc_stall), 64'd0);
    check("r_if_id",    64'(if_id_stall), 64'd0);
    check("r_bubble",   64'(id_ex_bubble), 64'd0);
    check("r_err",      64'(stall_err), 64'd0);
    check("r_cnt",      64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("r_after_release", 64'(pause_in), 64'(PAUSE_NO));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
